// File: rtl/gpr_scoreboard.sv
// GPR scoreboard: per-register countdown of in-flight multi-cycle results and the decode interlock.
// Optional SCOREBOARD_STALL_CNT_EN adds stall_count / stall_raw performance counters.
module gpr_scoreboard #(
    parameter int unsigned LAT_W = 4,
    parameter int unsigned NREG  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             issue_req,
    input  logic             flush,
    input  logic [4:0]       u_dst,
    input  logic             u_dst_en,
    input  logic [LAT_W-1:0] u_lat,
    input  logic [4:0]       l_dst,
    input  logic             l_dst_en,
    input  logic [LAT_W-1:0] l_lat,
    input  logic [14:0]      u_src_idx,
    input  logic [2:0]       u_src_en,
    input  logic [14:0]      l_src_idx,
    input  logic [2:0]       l_src_en,
    output logic             interlock,
    output logic             issue_fire,
    output logic [NREG-1:0]  busy_vec,
    output logic             busy_any
`ifdef SCOREBOARD_STALL_CNT_EN
    ,
    output logic [31:0]      stall_count,
    output logic [31:0]      stall_raw
`endif
);

    logic [LAT_W-1:0] cnt_q [NREG];
    logic [LAT_W-1:0] cnt_d [NREG];
    logic             raw_hazard;
    logic             waw_hazard;

    always_comb begin
        for (int i = 0; i < int'(NREG); i++) begin
            busy_vec[i] = (cnt_q[i] != '0);
        end
    end

    assign busy_any = |busy_vec;

    // Both slots read pre-bundle values, so only registered busy state matters here.
    always_comb begin
        raw_hazard = 1'b0;
        for (int s = 0; s < 3; s++) begin
            if (u_src_en[s] && busy_vec[u_src_idx[5*s +: 5]]) raw_hazard = 1'b1;
            if (l_src_en[s] && busy_vec[l_src_idx[5*s +: 5]]) raw_hazard = 1'b1;
        end
    end

    assign waw_hazard = (u_dst_en && busy_vec[u_dst]) || (l_dst_en && busy_vec[l_dst]);
    assign interlock  = issue_req && !flush && (raw_hazard || waw_hazard);
    assign issue_fire = issue_req && !flush && !interlock;

    always_comb begin
        logic [LAT_W-1:0] set_lat;
        for (int r = 0; r < int'(NREG); r++) begin
            set_lat = '0;
            if (issue_fire) begin
                if (u_dst_en && u_dst == 5'(r) && u_lat > set_lat) set_lat = u_lat;
                if (l_dst_en && l_dst == 5'(r) && l_lat > set_lat) set_lat = l_lat;
            end
            if (set_lat != '0) begin
                cnt_d[r] = set_lat;
            end else if (cnt_q[r] != '0) begin
                cnt_d[r] = cnt_q[r] - 1'b1;
            end else begin
                cnt_d[r] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < int'(NREG); r++) cnt_q[r] <= '0;
        end else begin
            for (int r = 0; r < int'(NREG); r++) cnt_q[r] <= cnt_d[r];
        end
    end

`ifdef SCOREBOARD_STALL_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_count <= '0;
            stall_raw   <= '0;
        end else begin
            if (interlock) stall_count <= stall_count + 32'd1;
            if (interlock && raw_hazard) stall_raw <= stall_raw + 32'd1;
        end
    end
`endif

endmodule
